ser_bit_counter: RTL and testbench



---
 rtl/ser_bit_counter.sv | 81 ++++++++
 tb/tb_ser_bit_counter.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/ser_bit_counter.sv
// rtl/ser_bit_counter.sv - bit-position counter for the 16-bit parallel-to-serial converter
module ser_bit_counter (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       data_val_i,
    input  logic [4:0] data_mod_i,
    input  logic       disable_i,
    output logic [4:0] count_o,
    output logic       overflow_o
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t     state;
    logic [4:0] len_q;
    logic [4:0] eff_len;
    logic       last_bit;
    logic       start_ok;

    // Length 0 encodes a full word; anything above 16 is clamped to a full word.
    always_comb begin
        eff_len = data_mod_i;
        if (data_mod_i == 5'd0 || data_mod_i > 5'd16) begin
            eff_len = 5'd16;
        end
    end

    assign last_bit = (count_o == 5'(len_q - 5'd1));
    assign start_ok = data_val_i && !disable_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state      <= ST_IDLE;
            count_o    <= 5'd0;
            overflow_o <= 1'b0;
            len_q      <= 5'd16;
        end else begin
            case (state)
                ST_IDLE: begin
                    count_o <= 5'd0;
                    if (start_ok) begin
                        state      <= ST_RUN;
                        overflow_o <= 1'b1;
                        len_q      <= eff_len;
                    end else begin
                        overflow_o <= 1'b0;
                    end
                end
                ST_RUN: begin
                    // Abort wins over both increment and back-to-back restart.
                    if (disable_i) begin
                        state      <= ST_IDLE;
                        count_o    <= 5'd0;
                        overflow_o <= 1'b0;
                    end else if (last_bit) begin
                        count_o <= 5'd0;
                        if (data_val_i) begin
                            overflow_o <= 1'b1;
                            len_q      <= eff_len;
                        end else begin
                            state      <= ST_IDLE;
                            overflow_o <= 1'b0;
                        end
                    end else begin
                        count_o    <= count_o + 5'd1;
                        overflow_o <= 1'b1;
                    end
                end
                default: begin
                    state      <= ST_IDLE;
                    count_o    <= 5'd0;
                    overflow_o <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ser_bit_counter.sv
// tb/tb_ser_bit_counter.sv - directed table-driven bench for ser_bit_counter
module tb_ser_bit_counter;

    logic       clk;
    logic       rst;
    logic       data_val;
    logic [4:0] data_mod;
    logic       dis;
    logic [4:0] count;
    logic       overflow;

    int tests_run = 0;
    int tests_failed = 0;

    typedef struct {
        logic       rst;
        logic       val;
        logic [4:0] mod;
        logic       dis;
        logic [4:0] exp_count;
        logic       exp_ov;
    } vec_t;

    vec_t vec_q[$];

    ser_bit_counter dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .data_val_i (data_val),
        .data_mod_i (data_mod),
        .disable_i  (dis),
        .count_o    (count),
        .overflow_o (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic add(input logic r, input logic v, input logic [4:0] m, input logic d,
                       input logic [4:0] c, input logic o);
        vec_t x;
        x.rst = r; x.val = v; x.mod = m; x.dis = d; x.exp_count = c; x.exp_ov = o;
        vec_q.push_back(x);
    endtask

    task automatic check(input string name, input int act, input int exp);
        tests_run++;
        if (act != exp) begin
            tests_failed++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step(input logic r, input logic v, input logic [4:0] m, input logic d);
        rst = r; data_val = v; data_mod = m; dis = d;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int cyc;
        int high;
        int max_cnt;

        rst = 1'b1; data_val = 1'b0; data_mod = 5'd0; dis = 1'b0;

        // Reset held with strobe high, then first start right after release (basic run, N=6)
        add(1, 1, 6, 0, 0, 0);
        add(1, 1, 6, 0, 0, 0);
        add(0, 1, 6, 0, 0, 1);
        for (int i = 1; i < 6; i++) add(0, 0, 6, 0, 5'(i), 1);
        add(0, 0, 6, 0, 0, 0);
        add(0, 0, 0, 0, 0, 0);
        // mod=0 -> 16 counts
        add(0, 1, 0, 0, 0, 1);
        for (int i = 1; i < 16; i++) add(0, 0, 0, 0, 5'(i), 1);
        add(0, 0, 0, 0, 0, 0);
        // mod=20 -> clamped to 16
        add(0, 1, 20, 0, 0, 1);
        for (int i = 1; i < 16; i++) add(0, 0, 20, 0, 5'(i), 1);
        add(0, 0, 20, 0, 0, 0);
        // mod=1 -> single cycle
        add(0, 1, 1, 0, 0, 1);
        add(0, 0, 1, 0, 0, 0);
        // latched 6, mod changed to 3 mid-run
        add(0, 1, 6, 0, 0, 1);
        for (int i = 1; i < 6; i++) add(0, 0, 3, 0, 5'(i), 1);
        add(0, 0, 3, 0, 0, 0);
        // back-to-back with mod=4
        add(0, 1, 4, 0, 0, 1);
        for (int i = 1; i < 4; i++) add(0, 1, 4, 0, 5'(i), 1);
        add(0, 1, 4, 0, 0, 1);
        for (int i = 1; i < 4; i++) add(0, 0, 4, 0, 5'(i), 1);
        add(0, 0, 4, 0, 0, 0);
        // back-to-back restart latches a new length (2 then 3)
        add(0, 1, 2, 0, 0, 1);
        add(0, 0, 2, 0, 1, 1);
        add(0, 1, 3, 0, 0, 1);
        add(0, 0, 9, 0, 1, 1);
        add(0, 0, 9, 0, 2, 1);
        add(0, 0, 9, 0, 0, 0);
        // disable in idle blocks start
        add(0, 1, 6, 1, 0, 0);
        add(0, 1, 6, 1, 0, 0);
        // disable at count 3 of 8 aborts
        add(0, 1, 8, 0, 0, 1);
        for (int i = 1; i < 4; i++) add(0, 0, 8, 0, 5'(i), 1);
        add(0, 0, 8, 1, 0, 0);
        add(0, 0, 8, 0, 0, 0);
        // disable on last bit beats restart
        add(0, 1, 2, 0, 0, 1);
        add(0, 0, 2, 0, 1, 1);
        add(0, 1, 2, 1, 0, 0);
        add(0, 0, 2, 0, 0, 0);
        // reset at count 5 of 10, then a fresh run of 10
        add(0, 1, 10, 0, 0, 1);
        for (int i = 1; i < 6; i++) add(0, 0, 10, 0, 5'(i), 1);
        add(1, 0, 10, 0, 0, 0);
        add(0, 1, 10, 0, 0, 1);
        for (int i = 1; i < 10; i++) add(0, 0, 10, 0, 5'(i), 1);
        add(0, 0, 10, 0, 0, 0);

        for (int i = 0; i < vec_q.size(); i++) begin
            step(vec_q[i].rst, vec_q[i].val, vec_q[i].mod, vec_q[i].dis);
            check($sformatf("vec%0d count", i), int'(count), int'(vec_q[i].exp_count));
            check($sformatf("vec%0d overflow", i), int'(overflow), int'(vec_q[i].exp_ov));
        end

        // mod=31 run: active for exactly 16 cycles, index never above 15
        step(0, 1, 31, 0);
        high = 0;
        max_cnt = 0;
        cyc = 0;
        while (overflow && cyc < 40) begin
            high++;
            if (int'(count) > max_cnt) max_cnt = int'(count);
            step(0, 0, 31, 0);
            cyc++;
        end
        check("mod31 timeout", int'(cyc < 40), 1);
        check("mod31 active cycles", high, 16);
        check("mod31 max index", max_cnt, 15);

        // continuous strobe with mod=4 over 3 words: no gaps in overflow
        step(0, 1, 4, 0);
        high = 0;
        for (int i = 0; i < 11; i++) begin
            if (overflow && int'(count) == (i % 4)) high++;
            step(0, 1, 4, 0);
        end
        if (overflow && int'(count) == 3) high++;
        check("b2b continuous words", high, 12);
        step(0, 0, 4, 0);
        check("b2b end overflow", int'(overflow), 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
